// File: rtl/prt_dp_pkg.sv
// Shared DP TX symbol codes and training-pattern type for the link-domain generators.
package prt_dp_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] K28_0     = 8'h1C;
  localparam logic [7:0] D10_2     = 8'h4A;
  localparam logic [7:0] D11_6     = 8'hCB;
  localparam logic [7:0] VBID_IDLE = 8'h09;

  typedef enum logic [1:0] {
    TPS_IDLE = 2'd0,
    TPS_1    = 2'd1,
    TPS_2    = 2'd2
  } tps_e;

  // Reserved encoding 3 falls back to TPS1.
  function automatic tps_e tps_decode(input logic [1:0] cfg);
    case (cfg)
      2'd0:    return TPS_IDLE;
      2'd2:    return TPS_2;
      default: return TPS_1;
    endcase
  endfunction

endpackage

// File: rtl/prt_dptx_trn_sym.sv
// Maps (pattern, symbol position, SR slot) to one 9-bit {K, data} symbol.
module prt_dptx_trn_sym
  import prt_dp_pkg::*;
#(
  parameter int P_POS_W = 4
) (
  input  tps_e               tps,
  input  logic [P_POS_W-1:0] pos,
  input  logic               sr,
  output logic [8:0]         sym
);

  always_comb begin
    sym = 9'h000;
    case (tps)
      TPS_1: sym = {1'b0, D10_2};
      TPS_2: begin
        if (pos == P_POS_W'(0) || pos == P_POS_W'(2))      sym = {1'b1, K28_5};
        else if (pos == P_POS_W'(1) || pos == P_POS_W'(3)) sym = {1'b0, D11_6};
        else                                               sym = {1'b0, D10_2};
      end
      default: begin
        // Idle: BS/SR, VB-ID, then Mvid/Maud and filler are all 0x00/D.
        if (pos == P_POS_W'(0))      sym = {1'b1, sr ? K28_0 : K28_5};
        else if (pos == P_POS_W'(1)) sym = {1'b0, VBID_IDLE};
      end
    endcase
  end

endmodule

// File: rtl/prt_dptx_trn_gen.sv
// DP TX training / idle pattern generator; identical stream on every lane, pattern
// changes held off until a TPS2 block boundary.
module prt_dptx_trn_gen
  import prt_dp_pkg::*;
#(
  parameter int P_LANES    = 4,
  parameter int P_SPL      = 2,
  parameter int P_IDLE_PER = 8192,
  parameter int P_SR_PER   = 512
) (
  input  logic                       CLK_IN,
  input  logic                       RST_IN,
  input  logic                       CFG_EN_IN,
  input  logic [1:0]                 CFG_TPS_IN,
  input  logic                       CFG_UPD_IN,
  output logic [1:0]                 STA_TPS_OUT,
  output logic                       STA_PEND_OUT,
  output logic [P_LANES*P_SPL*9-1:0] LNK_DAT_OUT,
  output logic                       LNK_BS_OUT
);

  localparam int SC_W  = $clog2(P_IDLE_PER);
  localparam int BS_W  = $clog2(P_SR_PER);
  localparam int POS_W = (SC_W > 4) ? SC_W : 4;

  tps_e                              act_q, pend_tps_q, cur_tps;
  logic                              pend_q, apply, slot, sr;
  logic [3:0]                        idx_q, cur_idx, idx_nxt;
  logic [4:0]                        idx_sum;
  logic [SC_W-1:0]                   sc_q, cur_sc;
  logic [BS_W-1:0]                   bs_cnt_q;
  logic [P_SPL-1:0][8:0]             sym;
  logic [P_LANES-1:0][P_SPL-1:0][8:0] dat_q;
  logic                              bs_q;

  // State counters hold the position of the next symbol to emit, so an apply
  // swaps pattern and restarts at index 0 on the very clock it takes effect.
  always_comb begin
    apply   = pend_q && (act_q != TPS_2 || idx_q == 4'd0);
    cur_tps = apply ? pend_tps_q : act_q;
    cur_idx = apply ? 4'd0 : idx_q;
    cur_sc  = apply ? '0 : sc_q;
    idx_sum = {1'b0, cur_idx} + 5'(P_SPL);
    idx_nxt = (idx_sum >= 5'd10) ? 4'(idx_sum - 5'd10) : idx_sum[3:0];
    slot    = CFG_EN_IN && cur_tps == TPS_IDLE && cur_sc == '0;
    sr      = bs_cnt_q == '0;
  end

  for (genvar j = 0; j < P_SPL; j++) begin : g_sym
    logic [4:0]       tsum;
    logic [POS_W-1:0] pos;
    always_comb begin
      tsum = {1'b0, cur_idx} + 5'(j);
      if (cur_tps == TPS_2) pos = POS_W'((tsum >= 5'd10) ? tsum - 5'd10 : tsum);
      else                  pos = POS_W'(cur_sc) + POS_W'(j);
    end
    prt_dptx_trn_sym #(.P_POS_W(POS_W)) u_sym (
      .tps (cur_tps),
      .pos (pos),
      .sr  (sr),
      .sym (sym[j])
    );
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      act_q      <= TPS_IDLE;
      pend_tps_q <= TPS_IDLE;
      pend_q     <= 1'b0;
      idx_q      <= '0;
      sc_q       <= '0;
      bs_cnt_q   <= '0;
      dat_q      <= '0;
      bs_q       <= 1'b0;
    end else begin
      // A strobe landing on an apply clock becomes the next pending request.
      if (CFG_UPD_IN) begin
        pend_q     <= 1'b1;
        pend_tps_q <= tps_decode(CFG_TPS_IN);
      end else if (apply) begin
        pend_q <= 1'b0;
      end
      act_q <= cur_tps;
      if (!CFG_EN_IN) begin
        idx_q    <= '0;
        sc_q     <= '0;
        bs_cnt_q <= '0;
        dat_q    <= '0;
        bs_q     <= 1'b0;
      end else begin
        idx_q <= (cur_tps == TPS_2) ? idx_nxt : 4'd0;
        sc_q  <= (cur_tps == TPS_IDLE) ? cur_sc + SC_W'(P_SPL) : '0;
        if (slot) bs_cnt_q <= bs_cnt_q + 1'b1;
        dat_q <= {P_LANES{sym}};
        bs_q  <= slot;
      end
    end
  end

  assign STA_TPS_OUT  = act_q;
  assign STA_PEND_OUT = pend_q;
  assign LNK_DAT_OUT  = dat_q;
  assign LNK_BS_OUT   = bs_q;

endmodule

// File: doc/prt_dptx_trn_gen.md
Name: prt_dptx_trn_gen

Overview:
- Link-domain training and idle pattern generator for the DP TX link path.
- Produces the per-lane 8b symbol stream (data plus K flag) that feeds the TX PHY encoder during link training (TPS1, TPS2) and during link idle (idle pattern with periodic BS/SR).
- The policy maker drives it through PIO-level config bits that are resynchronised into the link clock upstream.
- Pattern changes are boundary-aligned so the sink never sees a truncated TPS2 block.

Parameters:
- P_LANES, 4, number of lanes (1, 2 or 4); all lanes carry an identical stream.
- P_SPL, 2, symbols per lane per clock (2 or 4).
- P_IDLE_PER, 8192, idle period in symbols between BS/SR; must be a power of 2 and a multiple of P_SPL.
- P_SR_PER, 512, number of BS slots per SR; the first slot of each group emits SR.

Ports:
- CLK_IN  in  1  link clock
- RST_IN  in  1  synchronous, active-high reset
- CFG_EN_IN  in  1  generator enable; 0 forces zero output
- CFG_TPS_IN  in  2  requested pattern: 0 idle, 1 TPS1, 2 TPS2, 3 reserved (treated as TPS1)
- CFG_UPD_IN  in  1  single-cycle strobe; loads CFG_TPS_IN as the pending pattern
- STA_TPS_OUT  out  2  currently active pattern
- STA_PEND_OUT  out  1  high while an update is pending and not yet applied
- LNK_DAT_OUT  out  P_LANES*P_SPL*9  symbols; per lane i, symbol j: bit [(i*P_SPL+j)*9+8] = K, bits [(i*P_SPL+j)*9 +: 8] = data
- LNK_BS_OUT  out  1  pulses on a clock carrying BS or SR

Behaviour:
- Reset values (RST_IN sampled high):
  - active pattern = idle, pending cleared, all counters = 0.
  - LNK_DAT_OUT = 0, LNK_BS_OUT = 0, STA_TPS_OUT = 0, STA_PEND_OUT = 0.
  - Reset mid-pattern aborts immediately; no boundary wait.
- Output is registered, with 1-clock latency from the internal state to LNK_DAT_OUT.
- CFG_EN_IN = 0:
  - LNK_DAT_OUT = 0 and LNK_BS_OUT = 0 on the next clock.
  - Counters hold at 0; the pending mechanism still operates.
  - On re-enable the active pattern starts at symbol index 0.
- Symbol codes:
  - K28.5 = 0xBC/K, K28.0 (SR) = 0x1C/K.
  - D10.2 = 0x4A, D11.6 = 0xCB, VB-ID idle = 0x09, Mvid/Maud = 0x00.
- TPS1: every symbol D10.2, K = 0. Every clock is a boundary.
- TPS2:
  - 10-symbol block: K28.5, D11.6, K28.5, D11.6, then D10.2 x6.
  - Counter idx is 0..9 and advances by P_SPL mod 10 each clock; symbol j uses (idx+j) mod 10.
  - Boundary = clock where idx == 0 (every 5 clocks for P_SPL 2 or 4).
- Idle:
  - Symbol counter sc is log2(P_IDLE_PER) bits and advances by P_SPL, wrapping to 0.
  - Per lane: sc 0 = BS (K28.5), or SR when bs_cnt == 0; sc 1 = VB-ID; sc 2 = Mvid; sc 3 = Maud; all other symbols 0x00/D.
  - bs_cnt is log2(P_SR_PER) bits, increments after each BS/SR slot and wraps.
  - LNK_BS_OUT is high in the same cycle as the BS/SR symbol.
- Update handshake:
  - CFG_UPD_IN latches the pending pattern and raises STA_PEND_OUT on the next clock.
  - A new CFG_UPD_IN while pending overwrites the pending value (last write wins).
  - Apply rules:
    - If active = TPS1 or idle: apply on the clock after the latch.
    - If active = TPS2: apply on the clock where the next output would start at idx == 0.
  - On apply: the new pattern starts at symbol index 0, sc = 0, bs_cnt continues (not reset), STA_TPS_OUT updates, and STA_PEND_OUT clears in the same cycle.
  - Applying the same pattern as the active one restarts it at index 0.
  - If CFG_UPD_IN coincides with a boundary, the update is latched this clock and applied at the next eligible boundary.

Decomposition:
- prt_dp_pkg holds:
  - K/D symbol constants (K28_5, K28_0, D10_2, D11_6, VBID_IDLE).
  - A 2-bit enum for the pattern type: TPS_IDLE, TPS_1, TPS_2.
- One sub-module, prt_dptx_trn_sym: combinational mapping of (pattern, idx/sc, bs_cnt==0) to one 9-bit symbol.
  - Instantiated P_SPL times.
  - Lanes share the result by replication.

Test Plan:
- Reset, EN=1, idle, P_SPL=2: clock 1 lane symbols {0xBC/K SR? no — bs_cnt=0 so 0x1C/K, 0x09}, next {0x00,0x00}; a 2nd BS (0xBC/K) appears 4096 clocks later with LNK_BS_OUT=1; after 512 BS slots the SR recurs.
- UPD with TPS=1 from idle: STA_PEND pulses 1 clock, then every symbol on every lane = 0x4A K=0, STA_TPS_OUT=1.
- TPS2, P_SPL=4: clocks show BC/K CB BC/K CB | 4A x4 | 4A 4A BC/K CB | BC/K CB 4A 4A | 4A x4, repeating every 5 clocks.
- TPS2 active, UPD to TPS1 at idx=4 (P_SPL=2): TPS2 finishes symbols 4..9 (3 clocks), then 0x4A only; STA_PEND_OUT high exactly those 3 clocks.
- Two UPD strobes (TPS1, then idle) while TPS2 is pending: only idle is applied; BS emitted at the boundary.
- RST_IN high mid-TPS2 for 1 clock: next output is 0 and STA_TPS_OUT=0; idle resumes with SR at sc=0. Toggling EN low/high restarts at index 0.
